// File: rtl/vector_item_packer.sv
// vector_item_packer: gathers L-bit items into a vector of I slots and hands the
// complete vector to a consumer with a valid/ready handshake.
// The optional early-close feature is enabled by defining VECTOR_ITEM_PACKER_FLUSH_EN.
// Without that macro the flush input is present but ignored.
// out_count and the write pointer are 5 bits wide, so I must stay in the range 1..31.
module vector_item_packer #(
  parameter int I = 20,
  parameter int L = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [L-1:0]        in_item,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [I-1:0][L-1:0] out_vector,
  output logic [4:0]          out_count,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] LAST = 5'(I - 1);

  state_t state;
  state_t state_next;

  logic [4:0] wr_ptr;
  logic [4:0] wr_ptr_next;
  logic [4:0] count_q;
  logic [4:0] count_next;

  logic [I-1:0][L-1:0] vector_q;
  logic [I-1:0][L-1:0] vector_next;

  logic accept;
  logic release_vec;
  logic close_full;
  logic close_flush;

  // State register; reset abandons any partial or pending vector immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; in_ready/out_valid depend on state alone
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    release_vec = 1'b0;
    close_full  = 1'b0;
    close_flush = 1'b0;
    case (state)
      FILL: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        close_full = in_valid && (wr_ptr == LAST);
`ifdef VECTOR_ITEM_PACKER_FLUSH_EN
        close_flush = flush && (in_valid || (wr_ptr != 5'd0));
`endif
        if (close_full || close_flush) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid   = 1'b1;
        release_vec = out_ready;
        if (out_ready) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

`ifndef VECTOR_ITEM_PACKER_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  // Datapath next values: write the accepted item, advance the pointer and count,
  // clear the unused tail on an early close, and rewind both on release
  always_comb begin
    wr_ptr_next = wr_ptr;
    count_next  = count_q;
    vector_next = vector_q;
    if (accept) begin
      count_next = count_q + 5'd1;
      if (wr_ptr != LAST) begin
        wr_ptr_next = wr_ptr + 5'd1;
      end
    end
    for (int k = 0; k < I; k++) begin
      if (accept && (5'(k) == wr_ptr)) begin
        vector_next[k] = in_item;
      end else if (close_flush && (5'(k) >= count_next)) begin
        vector_next[k] = '0;
      end
    end
    if (release_vec) begin
      wr_ptr_next = 5'd0;
      count_next  = 5'd0;
    end
  end

  // Datapath registers; reset clears every slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 5'd0;
      count_q  <= 5'd0;
      vector_q <= '0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      count_q  <= count_next;
      vector_q <= vector_next;
    end
  end

  assign out_vector = vector_q;
  assign out_count  = count_q;

  wr_ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_ptr <= LAST);

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= 5'(I));

  hold_is_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_vector) && $stable(out_count)));

endmodule

// File: tb/tb_vector_item_packer.sv
// tb_vector_item_packer: directed stimulus for vector_item_packer, checked every
// cycle against a slot-array model plus hand-computed literal expectations.
// Flush scenarios follow whether VECTOR_ITEM_PACKER_FLUSH_EN is defined.
module tb_vector_item_packer;

  localparam int I = 20;
  localparam int L = 32;
  localparam int W = I * L;
`ifdef VECTOR_ITEM_PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [L-1:0]        in_item = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                flush = 1'b0;
  logic [I-1:0][L-1:0] out_vector;
  logic [4:0]          out_count;
  logic                out_valid;
  logic                out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] m_slots [I];
  int           m_n = 0;
  bit           m_hold = 1'b0;

  vector_item_packer #(.I(I), .L(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_item    (in_item),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_vector (out_vector),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [L-1:0] item, input logic valid,
                               input logic fl, input logic rdy);
    in_item   = item;
    in_valid  = valid;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] seqVector(input logic [L-1:0] base, input int n);
    logic [I-1:0][L-1:0] v;
    for (int k = 0; k < I; k++) begin
      v[k] = (k < n) ? base + L'(k) : '0;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] modelVector();
    logic [I-1:0][L-1:0] v;
    for (int k = 0; k < I; k++) begin
      v[k] = m_slots[k];
    end
    return v;
  endfunction

  task automatic resetDut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", W'(in_ready), W'(1'b1));
    checkOutput("rst_out_valid", W'(out_valid), W'(1'b0));
    checkOutput("rst_out_count", W'(out_count), W'(5'd0));
    checkOutput("rst_out_vector", W'(out_vector), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Behavioural model: a vector is a list of items filled from slot 0; it is
  // presented once it holds I items (or is closed early) until the consumer takes it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_n    = 0;
      for (int k = 0; k < I; k++) m_slots[k] = '0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_slots[m_n] = in_item;
        m_n = m_n + 1;
      end
      if (m_n == I) begin
        m_hold = 1'b1;
      end else if (FLUSH_EN && flush && (m_n > 0)) begin
        for (int k = m_n; k < I; k++) m_slots[k] = '0;
        m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
      m_n    = 0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_in_ready", W'(in_ready), W'(!m_hold));
      checkOutput("cyc_out_valid", W'(out_valid), W'(m_hold));
      checkOutput("cyc_out_count", W'(out_count), W'(m_n));
      checkOutput("cyc_out_vector", W'(out_vector), modelVector());
    end
  end

  initial begin
    logic [I-1:0][L-1:0] exp_v;

    resetDut();

    // Back-to-back stream with the consumer always ready
    for (int k = 0; k < I; k++) begin
      applyStimulus(32'h100 + 32'(k), 1'b1, 1'b0, 1'b1);
      if (k == I - 2) checkOutput("s1_valid_before_last", W'(out_valid), W'(1'b0));
    end
    checkOutput("s1_out_valid", W'(out_valid), W'(1'b1));
    checkOutput("s1_in_ready", W'(in_ready), W'(1'b0));
    checkOutput("s1_out_count", W'(out_count), W'(5'd20));
    checkOutput("s1_out_vector", W'(out_vector), seqVector(32'h100, 20));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_refill_count", W'(out_count), W'(5'd0));
    checkOutput("s1_refill_valid", W'(out_valid), W'(1'b0));

    // Consumer stalls for five cycles while items keep arriving
    for (int k = 0; k < I; k++) applyStimulus(32'h200 + 32'(k), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(32'hDEAD, 1'b1, 1'b0, 1'b0);
      checkOutput("s2_hold_valid", W'(out_valid), W'(1'b1));
      checkOutput("s2_hold_count", W'(out_count), W'(5'd20));
      checkOutput("s2_hold_vector", W'(out_vector), seqVector(32'h200, 20));
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_release_count", W'(out_count), W'(5'd0));
    checkOutput("s2_release_ready", W'(in_ready), W'(1'b1));
    checkOutput("s2_slot0_retained", W'(out_vector[0]), W'(32'h200));

    // Reset in the middle of a fill
    for (int k = 0; k < 7; k++) applyStimulus(32'h300 + 32'(k), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checkOutput("s3_rst_count", W'(out_count), W'(5'd0));
    checkOutput("s3_rst_valid", W'(out_valid), W'(1'b0));
    checkOutput("s3_rst_vector", W'(out_vector), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < I; k++) begin
      applyStimulus(32'h400 + 32'(k), 1'b1, 1'b0, 1'b0);
      if (k == I - 2) checkOutput("s3_valid_before_last", W'(out_valid), W'(1'b0));
    end
    checkOutput("s3_out_valid", W'(out_valid), W'(1'b1));
    checkOutput("s3_out_vector", W'(out_vector), seqVector(32'h400, 20));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);

`ifdef VECTOR_ITEM_PACKER_FLUSH_EN
    // Early close with an item accepted on the flush edge; stale slots are cleared
    applyStimulus(32'hA, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hB, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hC, 1'b1, 1'b1, 1'b0);
    exp_v    = '0;
    exp_v[0] = 32'hA;
    exp_v[1] = 32'hB;
    exp_v[2] = 32'hC;
    checkOutput("f1_out_valid", W'(out_valid), W'(1'b1));
    checkOutput("f1_out_count", W'(out_count), W'(5'd3));
    checkOutput("f1_out_vector", W'(out_vector), W'(exp_v));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);

    // Flush on an empty vector does nothing
    resetDut();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("f2_empty_valid", W'(out_valid), W'(1'b0));
    checkOutput("f2_empty_ready", W'(in_ready), W'(1'b1));
    checkOutput("f2_empty_count", W'(out_count), W'(5'd0));

    // Flush with items already written but none on the flush edge
    applyStimulus(32'h500, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h501, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("f3_out_valid", W'(out_valid), W'(1'b1));
    checkOutput("f3_out_count", W'(out_count), W'(5'd2));
    checkOutput("f3_out_vector", W'(out_vector), seqVector(32'h500, 2));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);

    // Flush while a full vector is held changes nothing
    for (int k = 0; k < I; k++) applyStimulus(32'h600 + 32'(k), 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("f4_hold_valid", W'(out_valid), W'(1'b1));
    checkOutput("f4_hold_count", W'(out_count), W'(5'd20));
    checkOutput("f4_hold_vector", W'(out_vector), seqVector(32'h600, 20));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
`else
    // Flush is ignored: the vector still closes only at I items
    exp_v = '0;
    for (int k = 0; k < 3; k++) applyStimulus(32'h700 + 32'(k), 1'b1, 1'b1, 1'b0);
    checkOutput("n1_out_valid", W'(out_valid), W'(1'b0));
    checkOutput("n1_out_count", W'(out_count), W'(5'd3));
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("n1_idle_flush_valid", W'(out_valid), W'(1'b0));
    for (int k = 3; k < I; k++) begin
      applyStimulus(32'h700 + 32'(k), 1'b1, 1'b0, 1'b0);
      if (k == I - 2) checkOutput("n1_valid_before_last", W'(out_valid), W'(1'b0));
    end
    checkOutput("n1_full_valid", W'(out_valid), W'(1'b1));
    checkOutput("n1_full_count", W'(out_count), W'(5'd20));
    checkOutput("n1_full_vector", W'(out_vector), seqVector(32'h700, 20) | W'(exp_v));
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
`endif

    for (int c = 0; c < 3; c++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
